// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its PLL / downstream logic.
// master: the supervisor itself; slave: the PLL and system-reset side.
interface pll_lock_supervisor_if;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       pll_fail;
   logic [2:0] state;
   logic [3:0] retry_count;
   logic [7:0] lock_loss_count;

   modport master (
      input  pll_locked,
      input  relock_req,
      output pll_rst,
      output sys_rst,
      output pll_fail,
      output state,
      output retry_count,
      output lock_loss_count
   );

   modport slave (
      output pll_locked,
      output relock_req,
      input  pll_rst,
      input  sys_rst,
      input  pll_fail,
      input  state,
      input  retry_count,
      input  lock_loss_count
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable lock, then releases sys_rst.
// Define PLL_SUPERVISOR_LOSS_COUNT_EN to build the saturating lock-loss counter.
module pll_lock_supervisor #(
   parameter int RST_PULSE_CYCLES   = 16,
   parameter int LOCK_TIMEOUT       = 100000,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES        = 8
) (
   input logic                   refclk,
   input logic                   rst,
   pll_lock_supervisor_if.master bus
);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUNNING   = 3'd3,
      FAILED    = 3'd4
   } state_t;

   localparam int PULSE_W = (RST_PULSE_CYCLES   > 1) ? $clog2(RST_PULSE_CYCLES)   : 1;
   localparam int TMO_W   = (LOCK_TIMEOUT       > 1) ? $clog2(LOCK_TIMEOUT)       : 1;
   localparam int STAB_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

   // Each counter runs 0 .. N-1, so the last value marks the final cycle of the phase.
   localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYCLES - 1);
   localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT - 1);
   localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [3:0]         RETRY_MAX  = 4'(MAX_RETRIES);

   logic               lock_meta_r;
   logic               lock_sync_r;
   state_t             state_r;
   state_t             state_nxt_s;
   logic [PULSE_W-1:0] pulse_cnt_r;
   logic [PULSE_W-1:0] pulse_cnt_nxt_s;
   logic [TMO_W-1:0]   tmo_cnt_r;
   logic [TMO_W-1:0]   tmo_cnt_nxt_s;
   logic [STAB_W-1:0]  stab_cnt_r;
   logic [STAB_W-1:0]  stab_cnt_nxt_s;
   logic [3:0]         retry_r;
   logic [3:0]         retry_nxt_s;
   logic               pll_rst_r;
   logic               sys_rst_r;
   logic               pll_fail_r;
   logic               enter_s;
   logic               loss_event_s;

   assign enter_s      = (state_nxt_s != state_r);
   assign loss_event_s = (state_r == RUNNING) && !lock_sync_r;

   // Two-flop synchronizer for the asynchronous PLL lock indication.
   always_ff @(posedge refclk) begin
      if (rst) begin
         lock_meta_r <= 1'b0;
         lock_sync_r <= 1'b0;
      end else begin
         lock_meta_r <= bus.pll_locked;
         lock_sync_r <= lock_meta_r;
      end
   end

   // Next-state and retry bookkeeping.
   always_comb begin
      state_nxt_s = state_r;
      retry_nxt_s = retry_r;
      case (state_r)
         RESET_PLL: begin
            if (pulse_cnt_r == PULSE_LAST) begin
               state_nxt_s = WAIT_LOCK;
            end else begin
               state_nxt_s = RESET_PLL;
            end
         end
         WAIT_LOCK: begin
            // A lock seen on the last timeout cycle still wins over the retry.
            if (lock_sync_r) begin
               state_nxt_s = STABILIZE;
            end else if (tmo_cnt_r == TMO_LAST) begin
               if (retry_r < RETRY_MAX) begin
                  retry_nxt_s = retry_r + 4'd1;
                  state_nxt_s = RESET_PLL;
               end else begin
                  state_nxt_s = FAILED;
               end
            end else begin
               state_nxt_s = WAIT_LOCK;
            end
         end
         STABILIZE: begin
            if (!lock_sync_r) begin
               state_nxt_s = WAIT_LOCK;
            end else if (stab_cnt_r == STAB_LAST) begin
               state_nxt_s = RUNNING;
               retry_nxt_s = 4'd0;
            end else begin
               state_nxt_s = STABILIZE;
            end
         end
         RUNNING: begin
            // Lock loss and relock in the same cycle collapse into one restart.
            if (loss_event_s || bus.relock_req) begin
               state_nxt_s = RESET_PLL;
               if (bus.relock_req) begin
                  retry_nxt_s = 4'd0;
               end else begin
                  retry_nxt_s = retry_r;
               end
            end else begin
               state_nxt_s = RUNNING;
            end
         end
         FAILED: begin
            if (bus.relock_req) begin
               state_nxt_s = RESET_PLL;
               retry_nxt_s = 4'd0;
            end else begin
               state_nxt_s = FAILED;
            end
         end
         default: begin
            state_nxt_s = RESET_PLL;
            retry_nxt_s = 4'd0;
         end
      endcase
   end

   // Phase counters: cleared on every state entry, otherwise count up and hold at the last value.
   always_comb begin
      pulse_cnt_nxt_s = pulse_cnt_r;
      tmo_cnt_nxt_s   = tmo_cnt_r;
      stab_cnt_nxt_s  = stab_cnt_r;
      if (enter_s) begin
         pulse_cnt_nxt_s = {PULSE_W{1'b0}};
         tmo_cnt_nxt_s   = {TMO_W{1'b0}};
         stab_cnt_nxt_s  = {STAB_W{1'b0}};
      end else begin
         case (state_r)
            RESET_PLL: begin
               if (pulse_cnt_r != PULSE_LAST) begin
                  pulse_cnt_nxt_s = pulse_cnt_r + PULSE_W'(1'b1);
               end else begin
                  pulse_cnt_nxt_s = pulse_cnt_r;
               end
            end
            WAIT_LOCK: begin
               if (tmo_cnt_r != TMO_LAST) begin
                  tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1'b1);
               end else begin
                  tmo_cnt_nxt_s = tmo_cnt_r;
               end
            end
            STABILIZE: begin
               if (stab_cnt_r != STAB_LAST) begin
                  stab_cnt_nxt_s = stab_cnt_r + STAB_W'(1'b1);
               end else begin
                  stab_cnt_nxt_s = stab_cnt_r;
               end
            end
            default: begin
               pulse_cnt_nxt_s = pulse_cnt_r;
               tmo_cnt_nxt_s   = tmo_cnt_r;
               stab_cnt_nxt_s  = stab_cnt_r;
            end
         endcase
      end
   end

   // State, counters and registered outputs; outputs are decoded from the next state so they align with state.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_r     <= RESET_PLL;
         pulse_cnt_r <= {PULSE_W{1'b0}};
         tmo_cnt_r   <= {TMO_W{1'b0}};
         stab_cnt_r  <= {STAB_W{1'b0}};
         retry_r     <= 4'd0;
         pll_rst_r   <= 1'b1;
         sys_rst_r   <= 1'b1;
         pll_fail_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         pulse_cnt_r <= pulse_cnt_nxt_s;
         tmo_cnt_r   <= tmo_cnt_nxt_s;
         stab_cnt_r  <= stab_cnt_nxt_s;
         retry_r     <= retry_nxt_s;
         pll_rst_r   <= (state_nxt_s == RESET_PLL) || (state_nxt_s == FAILED);
         sys_rst_r   <= (state_nxt_s != RUNNING);
         pll_fail_r  <= (state_nxt_s == FAILED);
      end
   end

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
   logic [7:0] loss_cnt_r;

   // Saturating count of lock losses observed while RUNNING.
   always_ff @(posedge refclk) begin
      if (rst) begin
         loss_cnt_r <= 8'd0;
      end else if (loss_event_s && (loss_cnt_r != 8'hFF)) begin
         loss_cnt_r <= loss_cnt_r + 8'd1;
      end else begin
         loss_cnt_r <= loss_cnt_r;
      end
   end

   assign bus.lock_loss_count = loss_cnt_r;
`else
   assign bus.lock_loss_count = 8'd0;
`endif

   assign bus.state       = state_r;
   assign bus.retry_count = retry_r;
   assign bus.pll_rst     = pll_rst_r;
   assign bus.sys_rst     = sys_rst_r;
   assign bus.pll_fail    = pll_fail_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed-random bench for pll_lock_supervisor; expected timing comes from phase arithmetic
// (sync latency, pulse, timeout and stable lengths) and a small loss/retry scoreboard.
module tb_pll_lock_supervisor;
   localparam int RST_PULSE = 4;
   localparam int TIMEOUT   = 20;
   localparam int STABLE    = 8;
   localparam int RETRIES   = 2;
   localparam int SYNC      = 2;

   logic refclk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   exp_loss = 0;
   int   n;
   int   d;
   logic [2:0] trace [1:14];

   pll_lock_supervisor_if bus_if ();

   pll_lock_supervisor #(
      .RST_PULSE_CYCLES   (RST_PULSE),
      .LOCK_TIMEOUT       (TIMEOUT),
      .LOCK_STABLE_CYCLES (STABLE),
      .MAX_RETRIES        (RETRIES)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .bus    (bus_if)
   );

   always #5 refclk = ~refclk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: lock seen after SYNC edges, one edge to enter STABILIZE, then STABLE cycles.
   function automatic int run_latency();
      return SYNC + 1 + STABLE;
   endfunction

   function automatic int loss_latency();
      return SYNC + 1;
   endfunction

   // Expected state t cycles after a single-cycle lock drop that began in STABILIZE.
   function automatic logic [2:0] glitch_state(input int t);
      if (t < SYNC + 1)              return 3'd2;
      else if (t == SYNC + 1)        return 3'd1;
      else if (t < SYNC + 2 + STABLE) return 3'd2;
      else                           return 3'd3;
   endfunction

   function automatic logic [7:0] loss_expected();
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
      return 8'(exp_loss);
`else
      return 8'd0;
`endif
   endfunction

   task automatic note_loss();
      if (exp_loss < 255) exp_loss++;
   endtask

   task automatic wait_state(input logic [2:0] target, input int bound, input string tag);
      int k = 0;
      while (bus_if.state !== target && k < bound) begin
         tick();
         k++;
      end
      check(tag, bus_if.state, target);
   endtask

   task automatic ticks_to_state(input logic [2:0] target, input int bound, output int k);
      k = 0;
      do begin
         tick();
         k++;
      end while (bus_if.state !== target && k < bound);
   endtask

   task automatic measure_level(input logic level, output int k);
      k = 0;
      while (bus_if.pll_rst === level && k < 100) begin
         k++;
         tick();
      end
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_state"},    bus_if.state,           3'd0);
      check({pfx, "_pll_rst"},  bus_if.pll_rst,         1'b1);
      check({pfx, "_sys_rst"},  bus_if.sys_rst,         1'b1);
      check({pfx, "_pll_fail"}, bus_if.pll_fail,        1'b0);
      check({pfx, "_retry"},    bus_if.retry_count,     4'd0);
      check({pfx, "_loss"},     bus_if.lock_loss_count, 8'd0);
   endtask

   initial begin
      rst = 1'b1;
      bus_if.pll_locked = 1'b0;
      bus_if.relock_req = 1'b0;

      // Reset state, then a full pulse after release.
      repeat (3) tick();
      check_reset_values("reset");
      rst = 1'b0;
      measure_level(1'b1, n);
      check("first_pulse_len", n, RST_PULSE);
      check("first_wait_state", bus_if.state, 3'd1);

      // Normal lock after a random delay inside WAIT_LOCK.
      d = $urandom_range(0, 12);
      repeat (d) tick();
      bus_if.pll_locked = 1'b1;
      ticks_to_state(3'd3, 40, n);
      check("lock_to_running", n, run_latency());
      check("running_sys_rst", bus_if.sys_rst, 1'b0);
      check("running_pll_rst", bus_if.pll_rst, 1'b0);
      check("running_retry", bus_if.retry_count, 4'd0);

      // Lock loss in RUNNING.
      repeat ($urandom_range(1, 10)) tick();
      bus_if.pll_locked = 1'b0;
      note_loss();
      n = 0;
      while (bus_if.sys_rst !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("loss_to_sys_rst", n, loss_latency());
      check("loss_state", bus_if.state, 3'd0);
      check("loss_count_1", bus_if.lock_loss_count, loss_expected());

      // Lock loss and relock in the same RUNNING cycle: one restart, loss still counted.
      bus_if.pll_locked = 1'b1;
      wait_state(3'd3, 60, "relock_running_entry");
      bus_if.pll_locked = 1'b0;
      repeat (SYNC) tick();
      bus_if.relock_req = 1'b1;
      tick();
      bus_if.relock_req = 1'b0;
      note_loss();
      check("both_state", bus_if.state, 3'd0);
      check("both_loss_count", bus_if.lock_loss_count, loss_expected());
      measure_level(1'b1, n);
      check("both_pulse_len", n, RST_PULSE);
      check("both_then_wait", bus_if.state, 3'd1);

      // Single-cycle lock glitch during STABILIZE.
      bus_if.pll_locked = 1'b1;
      wait_state(3'd2, 20, "glitch_stab_entry");
      repeat ($urandom_range(0, 3)) tick();
      bus_if.pll_locked = 1'b0;
      tick();
      trace[1] = bus_if.state;
      bus_if.pll_locked = 1'b1;
      for (int t = 2; t <= 14; t++) begin
         tick();
         trace[t] = bus_if.state;
      end
      for (int t = 1; t <= 14; t++) begin
         check($sformatf("glitch_t%0d", t), trace[t], glitch_state(t));
      end
      check("glitch_retry", bus_if.retry_count, 4'd0);

      // Loss again, then hold the lock low: timeouts, retries and FAILED.
      bus_if.pll_locked = 1'b0;
      note_loss();
      wait_state(3'd1, 20, "fail_wait_entry");
      check("loss_count_3", bus_if.lock_loss_count, loss_expected());
      measure_level(1'b0, n);
      check("first_gap", n, TIMEOUT);
      check("retry_1", bus_if.retry_count, 4'd1);
      measure_level(1'b1, n);
      check("retry1_pulse_len", n, RST_PULSE);
      // relock_req in WAIT_LOCK is ignored and does not restart the timeout.
      bus_if.relock_req = 1'b1;
      tick();
      bus_if.relock_req = 1'b0;
      check("wait_relock_state", bus_if.state, 3'd1);
      check("wait_relock_retry", bus_if.retry_count, 4'd1);
      measure_level(1'b0, n);
      check("second_gap", n, TIMEOUT - 1);
      check("retry_2", bus_if.retry_count, 4'd2);
      measure_level(1'b1, n);
      check("retry2_pulse_len", n, RST_PULSE);
      measure_level(1'b0, n);
      check("third_gap", n, TIMEOUT);
      check("failed_state", bus_if.state, 3'd4);
      check("failed_pll_fail", bus_if.pll_fail, 1'b1);
      check("failed_sys_rst", bus_if.sys_rst, 1'b1);
      check("failed_retry", bus_if.retry_count, 4'(RETRIES));
      repeat (30) tick();
      check("failed_hold_state", bus_if.state, 3'd4);
      check("failed_hold_pll_rst", bus_if.pll_rst, 1'b1);

      // Recovery from FAILED.
      bus_if.relock_req = 1'b1;
      tick();
      bus_if.relock_req = 1'b0;
      check("recover_state", bus_if.state, 3'd0);
      check("recover_retry", bus_if.retry_count, 4'd0);
      check("recover_pll_fail", bus_if.pll_fail, 1'b0);
      bus_if.pll_locked = 1'b1;
      wait_state(3'd3, 60, "recover_running");
      check("recover_sys_rst", bus_if.sys_rst, 1'b0);

      // One timeout, then a lock: retry_count clears on reaching RUNNING.
      bus_if.pll_locked = 1'b0;
      note_loss();
      n = 0;
      while (bus_if.retry_count !== 4'd1 && n < 60) begin
         tick();
         n++;
      end
      check("retry_then_lock_r1", bus_if.retry_count, 4'd1);
      wait_state(3'd1, 10, "retry_then_lock_wait");
      repeat ($urandom_range(0, 12)) tick();
      bus_if.pll_locked = 1'b1;
      ticks_to_state(3'd3, 40, n);
      check("retry_lock_latency", n, run_latency());
      check("retry_cleared", bus_if.retry_count, 4'd0);
      check("loss_count_4", bus_if.lock_loss_count, loss_expected());

      // Reset asserted in STABILIZE.
      bus_if.relock_req = 1'b1;
      tick();
      bus_if.relock_req = 1'b0;
      wait_state(3'd2, 40, "midrst_stab_entry");
      repeat ($urandom_range(0, 5)) tick();
      rst = 1'b1;
      tick();
      exp_loss = 0;
      check_reset_values("midrst");
      bus_if.pll_locked = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      rst = 1'b0;
      measure_level(1'b1, n);
      check("midrst_pulse_len", n, RST_PULSE);
      check("midrst_wait_state", bus_if.state, 3'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter RST_PULSE_CYCLES, default 16: refclk cycles for which pll_rst is held high per reset attempt (min 1).
REQ-002 Parameter LOCK_TIMEOUT, default 100000: refclk cycles to wait for lock before a retry (min 1).
REQ-003 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release (min 1).
REQ-004 Parameter MAX_RETRIES, default 8: number of timed-out attempts re-tried before entering FAILED (0 to 15).
REQ-005 refclk  in  1  free-running reference clock; single clock domain for all logic.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pll_locked  in  1  PLL lock indication; asynchronous to refclk.
REQ-008 relock_req  in  1  single-cycle request to restart the PLL reset sequence.
REQ-009 pll_rst  out  1  reset to the PLL, active high.
REQ-010 sys_rst  out  1  downstream reset, active high; low only in RUNNING.
REQ-011 pll_fail  out  1  high while in FAILED.
REQ-012 state  out  3  current state encoding: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUNNING=3, FAILED=4.
REQ-013 retry_count  out  4  timed-out attempts since the last successful lock or relock_req.
REQ-014 lock_loss_count  out  8  count of lock losses detected in RUNNING.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer (lock_sync) before any use; this adds 2 cycles of latency.
REQ-016 All outputs SHALL be registered.
REQ-017 RESET_PLL: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then the block enters WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0. lock_sync=1 moves the block to STABILIZE. After LOCK_TIMEOUT cycles without lock: if retry_count<MAX_RETRIES, retry_count increments and the block enters RESET_PLL; otherwise it enters FAILED.
REQ-019 STABILIZE: after LOCK_STABLE_CYCLES consecutive cycles of lock_sync=1, the block enters RUNNING and clears retry_count.
REQ-020 STABILIZE: lock_sync=0 on any cycle returns the block to WAIT_LOCK with the stable and timeout counters restarted; retry_count is unchanged.
REQ-021 RUNNING: sys_rst=0 on the cycle state reads 3, and remains 0 while in RUNNING.
REQ-022 RUNNING: lock_sync=0 asserts sys_rst=1 on the next cycle and enters RESET_PLL.
REQ-023 FAILED: pll_rst=1 and sys_rst=1 are held; the block remains in FAILED until relock_req or rst.
REQ-024 relock_req is honoured only in RUNNING or FAILED: it enters RESET_PLL and clears retry_count. In all other states it is ignored.
REQ-025 When lock loss and relock_req occur in the same RUNNING cycle, the block enters RESET_PLL once; the lock loss is still counted.
REQ-026 Each counter SHALL be sized by $clog2 of its parameter and reloaded on every state entry; no counter wraps.

Reset
REQ-027 On rst=1 the block SHALL enter RESET_PLL with pll_rst=1, sys_rst=1, pll_fail=0, state=0, retry_count=0, lock_loss_count=0, synchronizer flops=0 and internal counters=0.
REQ-028 rst asserted mid-sequence SHALL abort the sequence; RESET_PLL restarts with a full RST_PULSE_CYCLES pulse after rst is released.

Configuration
REQ-029 Macro PLL_SUPERVISOR_LOSS_COUNT_EN defined: lock_loss_count increments by 1 on each RUNNING lock loss and saturates at 255.
REQ-030 Macro PLL_SUPERVISOR_LOSS_COUNT_EN undefined: lock_loss_count is tied to 0, no counter logic is generated, and all other behaviour is identical.

Verification
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-031 Normal lock: release rst, raise pll_locked in WAIT_LOCK and hold it -> pll_rst high for exactly 4 cycles, RUNNING reached 2+8 cycles after lock rises (±1 for state entry), sys_rst=0, retry_count=0.
REQ-032 Timeout and fail: pll_locked held 0 -> three 4-cycle pll_rst pulses occur, each separated by 20 cycles, retry_count counts 1 then 2, then state=4, pll_fail=1, pll_rst=1.
REQ-033 Lock glitch: pll_locked drops for 1 cycle during STABILIZE -> state returns to 1, then completes 8 fresh stable cycles before RUNNING is entered.
REQ-034 Loss in RUNNING: pll_locked drops -> sys_rst=1 within 3 cycles, state=0, lock_loss_count=1 (macro defined) or 0 (macro undefined).
REQ-035 Recovery from FAILED: relock_req pulsed in FAILED -> state=0, retry_count=0, pll_fail=0; a subsequent lock reaches RUNNING. relock_req pulsed in WAIT_LOCK -> no effect.
REQ-036 Mid-operation reset: rst asserted in STABILIZE -> all REQ-027 values on the next cycle; after rst is released, a full 4-cycle pll_rst pulse is generated.
